// File: rtl/spam_csr_pkg.sv
// rtl/spam_csr_pkg.sv - shared constants and types for the SPAM CSR write dispatcher
package spam_csr_pkg;

    localparam int SPAM_ADDR_W  = 16;
    localparam int SPAM_DATA_W  = 32;
    localparam int SLOT_FIELD_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } csr_wr_state_e;

    // Slot field is sized for the largest window (16 slots) so the entry layout is fixed.
    typedef struct packed {
        logic [SLOT_FIELD_W-1:0] slot;
        logic [SPAM_DATA_W-1:0]  data;
    } csr_wr_entry_t;

endpackage

// File: rtl/csr_wr_fifo.sv
// rtl/csr_wr_fifo.sv - parameterized synchronous FIFO buffering decoded CSR writes
module csr_wr_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_b,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    // The extra pointer MSB separates full from empty once the write pointer has wrapped.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spam_csr_write_dispatch.sv
// rtl/spam_csr_write_dispatch.sv - decodes SPAM writes into CSR slots and issues them in order
module spam_csr_write_dispatch
    import spam_csr_pkg::*;
#(
    parameter int                WIDTH      = 32,
    parameter int                NCSR       = 4,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0100,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              spam_valid,
    input  logic              spam_r_nw,
    input  logic [ADDR_W-1:0] spam_addr,
    input  logic [WIDTH-1:0]  spam_wdata,
    output logic              spam_ack,
    output logic [NCSR-1:0]   csr_strobe,
    output logic [WIDTH-1:0]  csr_data,
    input  logic [NCSR-1:0]   csr_wait,
    output logic [7:0]        bad_addr_cnt
);

    localparam int OFS_W   = ADDR_W - 2;
    localparam int ENTRY_W = $bits(csr_wr_entry_t);

    csr_wr_state_e  r_state;
    logic           r_ack;
    logic [NCSR-1:0] r_strobe;
    logic [WIDTH-1:0] r_data;
    logic [7:0]     r_bad_cnt;

    logic [OFS_W-1:0] w_offset;
    logic           w_in_win;
    logic           w_write;
    logic           w_push;
    logic           w_reject;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [15:0]    w_wait_ext;
    csr_wr_entry_t  w_push_entry;
    csr_wr_entry_t  w_head;
    logic [ENTRY_W-1:0] w_head_raw;
    logic           w_unused_ok;

    // Word offset into the window; addresses below the base wrap to large values and miss.
    assign w_offset = spam_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign w_in_win = (w_offset < OFS_W'(NCSR));

    // A write is not considered in the ack cycle, so a request held across it is taken once.
    assign w_write  = spam_valid & ~spam_r_nw & ~r_ack;
    assign w_push   = w_write & w_in_win & ~w_full;
    assign w_reject = w_write & ~w_in_win;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.slot = w_offset[SLOT_FIELD_W-1:0];
        w_push_entry.data = SPAM_DATA_W'(spam_wdata);
    end

    csr_wr_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_b (rst_b),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_raw)
    );

    assign w_head     = csr_wr_entry_t'(w_head_raw);
    assign w_wait_ext = 16'(csr_wait);
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty & ~w_wait_ext[w_head.slot];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= ST_IDLE;
            r_strobe <= '0;
            r_data   <= '0;
        end else begin
            r_strobe <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_strobe <= NCSR'(1) << w_head.slot;
                        r_data   <= w_head.data[WIDTH-1:0];
                        r_state  <= ST_SETTLE;
                    end
                end
                // One quiet cycle lets the target synchronizer raise its wait flag.
                ST_SETTLE: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ack     <= 1'b0;
            r_bad_cnt <= '0;
        end else begin
            r_ack <= w_push | w_reject;
            if (w_reject && (r_bad_cnt != 8'hFF)) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    assign w_unused_ok = &{1'b0, spam_addr[1:0]};

    assign spam_ack     = r_ack;
    assign csr_strobe   = r_strobe;
    assign csr_data     = r_data;
    assign bad_addr_cnt = r_bad_cnt;

endmodule

// File: tb/tb_spam_csr_write_dispatch.sv
// tb/tb_spam_csr_write_dispatch.sv - randomized self-checking bench with an in-order write model
module tb_spam_csr_write_dispatch;

    localparam int          NCSR  = 4;
    localparam int          WIDTH = 32;
    localparam logic [15:0] BASE  = 16'h0100;

    logic              clk = 1'b0;
    logic              rst_b;
    logic              spam_valid;
    logic              spam_r_nw;
    logic [15:0]       spam_addr;
    logic [WIDTH-1:0]  spam_wdata;
    logic              spam_ack;
    logic [NCSR-1:0]   csr_strobe;
    logic [WIDTH-1:0]  csr_data;
    logic [NCSR-1:0]   csr_wait;
    logic [7:0]        bad_addr_cnt;

    typedef struct {
        int               slot;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               exp_bad;
    logic [WIDTH-1:0] exp_last;
    logic [NCSR-1:0]  wait_at_edge;
    logic [NCSR-1:0]  prev_strobe;
    bit               mon_en;
    bit               rand_wait;
    int               n_checks;
    int               n_fails;

    spam_csr_write_dispatch u_dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .spam_valid   (spam_valid),
        .spam_r_nw    (spam_r_nw),
        .spam_addr    (spam_addr),
        .spam_wdata   (spam_wdata),
        .spam_ack     (spam_ack),
        .csr_strobe   (csr_strobe),
        .csr_data     (csr_data),
        .csr_wait     (csr_wait),
        .bad_addr_cnt (bad_addr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [15:0] a);
        int d;
        d = int'(a[15:2]) - int'(BASE[15:2]);
        return (d >= 0 && d < NCSR) ? d : -1;
    endfunction

    function automatic int sat_bad();
        return (exp_bad > 255) ? 255 : exp_bad;
    endfunction

    always @(posedge clk) wait_at_edge = csr_wait;

    // Every strobe must match the oldest accepted write; between strobes the data is held.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_b) begin
            if (csr_strobe != '0) begin
                check_eq("strobe_onehot", $countones(csr_strobe), 1);
                check_eq("strobe_gap", prev_strobe, 0);
                if (exp_q.size() == 0) begin
                    check_eq("strobe_unexpected", csr_strobe, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("strobe_slot", csr_strobe, 64'(1) << e.slot);
                    check_eq("strobe_data", csr_data, e.data);
                    check_eq("wait_honoured", wait_at_edge & csr_strobe, 0);
                    exp_last = e.data;
                end
            end else begin
                check_eq("data_held", csr_data, exp_last);
            end
            prev_strobe = csr_strobe;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_wait) csr_wait = NCSR'($urandom & $urandom);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [WIDTH-1:0] d, input bit hold,
                            input int bound, output int lat);
        int s;
        spam_valid = 1'b1;
        spam_r_nw  = 1'b0;
        spam_addr  = a;
        spam_wdata = d;
        lat        = -1;
        for (int c = 1; c <= bound; c++) begin
            tick();
            if (spam_ack) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            s = slot_of(a);
            if (s >= 0) exp_q.push_back('{slot: s, data: d});
            else exp_bad++;
            check_eq("bad_cnt", bad_addr_cnt, sat_bad());
            if (hold) begin
                tick();
                check_eq("no_double_ack", spam_ack, 0);
            end
            spam_valid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [15:0] a);
        spam_valid = 1'b1;
        spam_r_nw  = 1'b1;
        spam_addr  = a;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("read_no_ack", spam_ack, 0);
        end
        spam_valid = 1'b0;
        spam_r_nw  = 1'b0;
        check_eq("read_bad_cnt", bad_addr_cnt, sat_bad());
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) tick();
        tick();
        tick();
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int kind;
        int s;
        logic [15:0] a;

        n_checks = 0; n_fails = 0; exp_bad = 0; exp_last = '0;
        prev_strobe = '0; mon_en = 0; rand_wait = 0;
        rst_b = 1'b0; spam_valid = 0; spam_r_nw = 0; spam_addr = '0; spam_wdata = '0; csr_wait = '0;

        repeat (3) tick();
        check_eq("rst_ack", spam_ack, 0);
        check_eq("rst_strobe", csr_strobe, 0);
        check_eq("rst_data", csr_data, 0);
        check_eq("rst_bad_cnt", bad_addr_cnt, 0);
        rst_b  = 1'b1;
        mon_en = 1;
        tick();

        // Single write to slot 3
        do_write(16'h010C, 32'hDEADBEEF, 0, 10, lat);
        check_eq("t1_ack_latency", lat, 1);
        tick();
        check_eq("t1_strobe", csr_strobe, 4'b1000);
        check_eq("t1_data", csr_data, 32'hDEADBEEF);
        tick();
        check_eq("t1_strobe_off", csr_strobe, 0);
        check_eq("t1_data_held", csr_data, 32'hDEADBEEF);

        // Wait honoured on slot 1
        csr_wait = 4'b0010;
        do_write(16'h0104, 32'h5, 0, 10, lat);
        check_eq("t2_ack_latency", lat, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_no_strobe", csr_strobe, 0);
        end
        csr_wait = 4'b0000;
        tick();
        check_eq("t2_strobe", csr_strobe, 4'b0010);
        tick();

        // FIFO full: fifth write stalls until an entry drains
        csr_wait = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            do_write(BASE + 16'(4 * i), 32'(i + 1), 0, 10, lat);
            check_eq("t3_acked", lat > 0, 1);
        end
        do_write(BASE, 32'd5, 0, 10, lat);
        check_eq("t3_full_noack", lat, -1);
        check_eq("t3_full_nostrobe", csr_strobe, 0);
        csr_wait = 4'b0000;
        do_write(BASE, 32'd5, 0, 20, lat);
        check_eq("t3_fifth_acked", lat > 0, 1);
        drain();

        // Head-of-line blocking: slot 0 waits behind a blocked slot 2
        csr_wait = 4'b0100;
        do_write(16'h0108, 32'hA0A0A0A0, 0, 10, lat);
        check_eq("t4_acked_a", lat > 0, 1);
        do_write(16'h0100, 32'hB0B0B0B0, 0, 10, lat);
        check_eq("t4_acked_b", lat > 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t4_blocked", csr_strobe, 0);
        end
        csr_wait = 4'b0000;
        drain();

        // Out-of-window writes saturate the counter; reads are ignored
        for (int i = 0; i < 300; i++) begin
            do_write(16'h0200, WIDTH'($urandom), 0, 10, lat);
            check_eq("t5_bad_acked", lat > 0, 1);
        end
        check_eq("t5_bad_sat", bad_addr_cnt, 8'hFF);
        do_read(16'h0104);
        check_eq("t5_no_push", exp_q.size(), 0);

        // Randomized traffic with random wait flags and held requests
        rand_wait = 1;
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                s = $urandom_range(0, NCSR - 1);
                a = BASE + 16'(4 * s) + 16'($urandom_range(0, 3));
            end else begin
                a = 16'($urandom);
            end
            if (kind >= 8) begin
                do_read(a);
            end else begin
                do_write(a, WIDTH'($urandom), 1'($urandom), 200, lat);
                check_eq("t6_acked", lat > 0, 1);
            end
        end
        rand_wait = 0;
        csr_wait  = '0;
        drain();

        // Reset while a strobe is active and entries are queued
        csr_wait = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            do_write(BASE + 16'(4 * i), 32'hC0DE0000 + 32'(i), 0, 10, lat);
            check_eq("t7_acked", lat > 0, 1);
        end
        csr_wait = 4'b0000;
        tick();
        check_eq("t7_strobe_active", csr_strobe, 4'b0001);
        #2;
        rst_b = 1'b0;
        #1;
        check_eq("t7_async_strobe", csr_strobe, 0);
        check_eq("t7_async_cnt", bad_addr_cnt, 0);
        check_eq("t7_async_data", csr_data, 0);
        exp_q.delete();
        exp_bad     = 0;
        exp_last    = '0;
        prev_strobe = '0;
        tick();
        tick();
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t7_no_stale", csr_strobe, 0);
            check_eq("t7_no_ack", spam_ack, 0);
        end
        check_eq("t7_cnt_zero", bad_addr_cnt, 0);
        check_eq("t7_data_zero", csr_data, 0);
        do_write(16'h0108, 32'h12345678, 0, 10, lat);
        check_eq("t7_post_ack", lat, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
